// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronises and filters the PS/2 clock, assembles 11-bit
// frames, checks start/parity/stop, and stores good bytes in a show-ahead FIFO.
// Sticky flags report dropped bytes and bad or timed-out frames.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rd_en,
    input  logic               err_clr,
    output logic [7:0]         data,
    output logic               ready,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    output logic               frame_err
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned LW     = FIFO_AW + 1;
    localparam int unsigned IDLE_W = 20;

    // synchroniser, filter and strobe state
    logic              r_clk_s1, r_clk_s2;
    logic              r_dat_s1, r_dat_s2;
    logic              r_filt_clk;
    logic              r_filt_clk_d;
    logic [3:0]        r_filt_cnt;
    logic              w_strobe;

    // frame assembly state
    logic [3:0]        r_bit_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [7:0]        r_sh;
    logic              r_start;
    logic              r_par;
    logic              w_last;
    logic              w_frame_ok;
    logic              w_frame_bad;
    logic              w_timeout;

    // FIFO state
    logic [7:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_ready;
    logic              r_overflow;
    logic              r_frame_err;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [LW-1:0]     w_level_nxt;

    // Two-flop synchronisers for both PS/2 lines; idle bus level is 1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_filt_clk   <= 1'b1;
            r_filt_cnt   <= 4'd0;
            r_filt_clk_d <= 1'b1;
        end else begin
            r_filt_clk_d <= r_filt_clk;
            if (r_clk_s2 != r_filt_clk) begin
                if (r_filt_cnt == 4'(FILTER_LEN - 1)) begin
                    r_filt_clk <= r_clk_s2;
                    r_filt_cnt <= 4'd0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 4'd1;
                end
            end else begin
                r_filt_cnt <= 4'd0;
            end
        end
    end

    // One-cycle strobe on the falling edge of the filtered clock.
    assign w_strobe = r_filt_clk_d & ~r_filt_clk;

    // Frame-level decode of the 11th bit and of the idle timeout.
    always_comb begin
        w_last      = w_strobe && (r_bit_cnt == 4'd10);
        w_frame_ok  = w_last && !r_start && r_dat_s2 && (^{r_sh, r_par});
        w_frame_bad = w_last && !w_frame_ok;
        w_timeout   = (r_bit_cnt != 4'd0) && !w_strobe &&
                      (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
    end

    // Bit counter, shift register and idle counter for frame assembly.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bit_cnt  <= 4'd0;
            r_idle_cnt <= '0;
            r_sh       <= 8'd0;
            r_start    <= 1'b0;
            r_par      <= 1'b0;
        end else if (w_strobe) begin
            r_idle_cnt <= '0;
            if (r_bit_cnt == 4'd0) begin
                r_start <= r_dat_s2;
            end else if (r_bit_cnt == 4'd9) begin
                r_par <= r_dat_s2;
            end else if (r_bit_cnt != 4'd10) begin
                r_sh <= {r_dat_s2, r_sh[7:1]};
            end
            r_bit_cnt <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd0) begin
            r_idle_cnt <= '0;
        end else if (w_timeout) begin
            r_bit_cnt  <= 4'd0;
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    // FIFO push/pop decisions; a pop in the same cycle frees room for a full push.
    always_comb begin
        w_full      = (r_level == LW'(DEPTH));
        w_pop       = rd_en && (r_level != '0);
        w_push      = w_frame_ok && (!w_full || rd_en);
        w_drop      = w_frame_ok && w_full && !rd_en;
        w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_sh;
        end
    end

    // Pointers, level and registered non-empty flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != '0);
        end
    end

    // Sticky error flags; a new event outranks err_clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_bad || w_timeout) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign data      = r_mem[r_rd_ptr];
    assign ready     = r_ready;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
